// File: rtl/mux_sel_sequencer.sv
// rtl/mux_sel_sequencer.sv - parallel-to-serial select sequencer for an 8:1 bit mux
//
// Captures an 8-bit word over a valid/ready handshake, holds it on the mux data
// bus and steps the 3-bit select through all bit positions, holding each index
// for CLKS_PER_BIT cycles. All outputs are registered.
//
// Parameters
//   CLKS_PER_BIT  cycles each bit index is held (1..256)
//   MSB_FIRST     0: sel steps 0->7, 1: sel steps 7->0
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_data    word to serialize
//   in_valid   in_data is valid
//   in_ready   block can accept a word
//   d          captured word (mux data input)
//   sel        bit index (mux select)
//   bit_valid  mux output carries a valid serial bit this cycle
//   bit_first  current bit is the first of eight
//   bit_last   current bit is the last of eight
//   busy       word in progress
//   done       one-cycle pulse after the last bit completes

module mux_sel_sequencer #(
    parameter int CLKS_PER_BIT = 1,
    parameter bit MSB_FIRST    = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] d,
    output logic [2:0] sel,
    output logic       bit_valid,
    output logic       bit_first,
    output logic       bit_last,
    output logic       busy,
    output logic       done
);

    localparam logic [7:0] CNT_MAX   = 8'(CLKS_PER_BIT - 1);
    localparam logic [2:0] SEL_START = MSB_FIRST ? 3'd7 : 3'd0;
    localparam logic [2:0] SEL_END   = MSB_FIRST ? 3'd0 : 3'd7;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t     state, state_n;
    logic [7:0] cnt, cnt_n;
    logic [7:0] d_n;
    logic [2:0] sel_n;
    logic       in_ready_n;
    logic       bit_valid_n;
    logic       bit_first_n;
    logic       bit_last_n;
    logic       busy_n;
    logic       done_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            d         <= 8'd0;
            sel       <= SEL_START;
            in_ready  <= 1'b0;
            bit_valid <= 1'b0;
            bit_first <= 1'b0;
            bit_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            d         <= d_n;
            sel       <= sel_n;
            in_ready  <= in_ready_n;
            bit_valid <= bit_valid_n;
            bit_first <= bit_first_n;
            bit_last  <= bit_last_n;
            busy      <= busy_n;
            done      <= done_n;
        end
    end

    // Every output is computed one cycle ahead here so that the registered
    // value lines up with the state it describes.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        d_n         = d;
        sel_n       = sel;
        in_ready_n  = in_ready;
        bit_valid_n = 1'b0;
        busy_n      = 1'b0;
        done_n      = 1'b0;

        case (state)
            IDLE: begin
                cnt_n      = 8'd0;
                // in_ready is still low in the first cycle after reset, so
                // acceptance cannot happen until it has been set here once.
                in_ready_n = 1'b1;
                if (in_valid && in_ready) begin
                    d_n         = in_data;
                    sel_n       = SEL_START;
                    state_n     = SHIFT;
                    in_ready_n  = 1'b0;
                    bit_valid_n = 1'b1;
                    busy_n      = 1'b1;
                end
            end
            SHIFT: begin
                in_ready_n  = 1'b0;
                bit_valid_n = 1'b1;
                busy_n      = 1'b1;
                if (cnt == CNT_MAX) begin
                    cnt_n = 8'd0;
                    if (sel == SEL_END) begin
                        state_n     = IDLE;
                        sel_n       = SEL_START;
                        in_ready_n  = 1'b1;
                        done_n      = 1'b1;
                        bit_valid_n = 1'b0;
                        busy_n      = 1'b0;
                    end else begin
                        sel_n = MSB_FIRST ? sel - 3'd1 : sel + 3'd1;
                    end
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        bit_first_n = bit_valid_n && (sel_n == SEL_START);
        bit_last_n  = bit_valid_n && (sel_n == SEL_END);
    end

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// tb/tb_mux_sel_sequencer.sv - self-checking bench for mux_sel_sequencer

module tb_mux_sel_sequencer;

    localparam int N    = 3;
    localparam int CPB0 = 1;
    localparam int CPB1 = 3;
    localparam int CPB2 = 2;
    localparam bit MSB0 = 1'b0;
    localparam bit MSB1 = 1'b0;
    localparam bit MSB2 = 1'b1;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;

    logic       ready_o [N];
    logic [7:0] d_o     [N];
    logic [2:0] sel_o   [N];
    logic       bv_o    [N];
    logic       first_o [N];
    logic       last_o  [N];
    logic       busy_o  [N];
    logic       done_o  [N];

    always #5 clk = ~clk;

    mux_sel_sequencer #(.CLKS_PER_BIT(CPB0), .MSB_FIRST(MSB0)) u0 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(ready_o[0]), .d(d_o[0]), .sel(sel_o[0]), .bit_valid(bv_o[0]),
        .bit_first(first_o[0]), .bit_last(last_o[0]), .busy(busy_o[0]), .done(done_o[0])
    );

    mux_sel_sequencer #(.CLKS_PER_BIT(CPB1), .MSB_FIRST(MSB1)) u1 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(ready_o[1]), .d(d_o[1]), .sel(sel_o[1]), .bit_valid(bv_o[1]),
        .bit_first(first_o[1]), .bit_last(last_o[1]), .busy(busy_o[1]), .done(done_o[1])
    );

    mux_sel_sequencer #(.CLKS_PER_BIT(CPB2), .MSB_FIRST(MSB2)) u2 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(ready_o[2]), .d(d_o[2]), .sel(sel_o[2]), .bit_valid(bv_o[2]),
        .bit_first(first_o[2]), .bit_last(last_o[2]), .busy(busy_o[2]), .done(done_o[2])
    );

    // Reference model: each instance is described only by the cycle of its
    // last acceptance and the word taken then; everything else follows from
    // the timing rules by arithmetic on the current cycle number.
    int         cpb  [N] = '{CPB0, CPB1, CPB2};
    bit         msbf [N] = '{MSB0, MSB1, MSB2};
    int         acc  [N];
    logic [7:0] word [N];
    int         rst_cycle;
    bit         seen_rst;
    int         cyc;
    int         checks;
    int         errors;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Bit position presented by instance i in cycle n, or -1 when no bit is presented.
    function automatic int bitpos(input int i, input int n);
        int rel;
        int k;
        if (acc[i] < 0) return -1;
        rel = n - acc[i];
        if (rel < 1 || rel > 8 * cpb[i]) return -1;
        k = (rel - 1) / cpb[i];
        return msbf[i] ? 7 - k : k;
    endfunction

    function automatic bit exp_ready(input int i, input int n);
        return (n >= rst_cycle + 2) && (bitpos(i, n) < 0);
    endfunction

    task automatic check_outputs(input int n);
        int pos;
        int start;
        int fin;
        bit dn;
        logic [7:0] dv;
        logic [2:0] sv;
        for (int i = 0; i < N; i++) begin
            pos   = bitpos(i, n);
            start = msbf[i] ? 7 : 0;
            fin   = msbf[i] ? 0 : 7;
            dn    = (acc[i] >= 0) && (n - acc[i] == 8 * cpb[i] + 1);
            check($sformatf("u%0d.in_ready", i), 32'(ready_o[i]), 32'(exp_ready(i, n)));
            check($sformatf("u%0d.d", i), 32'(d_o[i]), 32'(word[i]));
            check($sformatf("u%0d.sel", i), 32'(sel_o[i]), 32'((pos >= 0) ? pos : start));
            check($sformatf("u%0d.bit_valid", i), 32'(bv_o[i]), 32'(pos >= 0));
            check($sformatf("u%0d.bit_first", i), 32'(first_o[i]), 32'((pos >= 0) && (pos == start)));
            check($sformatf("u%0d.bit_last", i), 32'(last_o[i]), 32'((pos >= 0) && (pos == fin)));
            check($sformatf("u%0d.busy", i), 32'(busy_o[i]), 32'(pos >= 0));
            check($sformatf("u%0d.done", i), 32'(done_o[i]), 32'(dn));
            if (pos >= 0) begin
                dv = d_o[i];
                sv = sel_o[i];
                check($sformatf("u%0d.y", i), 32'(dv[sv]), 32'(word[i][pos[2:0]]));
            end
        end
    endtask

    task automatic update_model(input int n);
        if (rst) begin
            rst_cycle = n;
            seen_rst  = 1'b1;
            for (int i = 0; i < N; i++) begin
                acc[i]  = -1;
                word[i] = 8'h00;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (seen_rst && exp_ready(i, n) && in_valid) begin
                    acc[i]  = n;
                    word[i] = in_data;
                end
            end
        end
    endtask

    initial begin
        bit mid_rst_done;
        rst          = 1'b1;
        in_valid     = 1'b0;
        in_data      = 8'h00;
        cyc          = 0;
        checks       = 0;
        errors       = 0;
        rst_cycle    = 0;
        seen_rst     = 1'b0;
        mid_rst_done = 1'b0;
        for (int i = 0; i < N; i++) begin
            acc[i]  = -1;
            word[i] = 8'h00;
        end

        while (cyc < 3400) begin
            @(posedge clk);
            cyc++;
            #1;
            rst = (cyc <= 2);
            if (cyc <= 2) begin
                in_valid = 1'b0;
                in_data  = 8'h00;
            end else if (cyc <= 80) begin
                in_valid = 1'b1;
                in_data  = 8'hA5;
            end else if (cyc <= 160) begin
                in_valid = (cyc > 84);
                in_data  = 8'h3C;
            end else if (cyc <= 240) begin
                in_valid = 1'b1;
                in_data  = 8'h81;
            end else if (cyc <= 300) begin
                // held valid with data changing every cycle: back-to-back words
                in_valid = 1'b1;
                in_data  = 8'($urandom);
            end else if (cyc <= 400) begin
                in_valid = 1'b1;
                in_data  = 8'($urandom);
                if (!mid_rst_done && bitpos(0, cyc) == 4) begin
                    rst          = 1'b1;
                    mid_rst_done = 1'b1;
                end
            end else begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = 8'($urandom);
                rst      = ($urandom_range(0, 199) == 0);
            end
            @(negedge clk);
            if (seen_rst) check_outputs(cyc);
            update_model(cyc);
        end

        check("mid_word_reset_hit", 32'(mid_rst_done), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_sel_sequencer.md
# mux_sel_sequencer

Parallel-to-serial front end for the 8:1 bit-select multiplexer. It accepts an 8-bit word over a valid/ready handshake and holds it stable on the mux data bus. It then steps the 3-bit select through all eight bit positions at a programmable rate, so that the downstream mux output forms a serial bitstream. It also flags which cycles carry valid bits and marks frame boundaries for the serial consumer.

## Interface
- CLKS_PER_BIT, 1, clock cycles each bit index is held; legal range 1..256
- MSB_FIRST, 0, 0: sel steps 0→7; 1: sel steps 7→0
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_data  input  8  word to serialize
- in_valid  input  1  in_data is valid
- in_ready  output  1  block can accept a word (registered)
- d  output  8  captured word, drives mux data input
- sel  output  3  bit index, drives mux select
- bit_valid  output  1  mux output is a valid serial bit this cycle
- bit_first  output  1  current bit is bit 1 of 8
- bit_last  output  1  current bit is bit 8 of 8
- busy  output  1  word in progress
- done  output  1  one-cycle pulse after the last bit completes

## Operation
- Clocking and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values (all outputs): in_ready=0, d=0, sel=0 (7 if MSB_FIRST), bit_valid=0, bit_first=0, bit_last=0, busy=0, done=0. State is IDLE.
- States are IDLE and SHIFT.
- IDLE
  - in_ready=1, except in the first cycle after reset release.
  - Acceptance is in_valid && in_ready sampled at a rising edge. On acceptance: d←in_data, sel←start index, hold counter←0, next state SHIFT.
- SHIFT
  - busy=1 and bit_valid=1 in every SHIFT cycle; in_ready=0.
  - The hold counter counts 0..CLKS_PER_BIT-1. At terminal count the counter clears and sel advances by ±1 (no wrap).
  - bit_first=1 while sel equals the start index. bit_last=1 while sel equals the end index (7, or 0 if MSB_FIRST).
  - At terminal count on the end index: state goes to IDLE, done=1 for one cycle, in_ready=1 in that same cycle, and sel returns to the start index.
- d is stable throughout SHIFT and retained in IDLE until the next acceptance. Changes on in_data outside acceptance have no effect.
- in_valid is ignored whenever in_ready=0. There is no skid buffer.
- Reset mid-word aborts the word. The next edge applies the reset values; done is not pulsed.
- The counter is sized for 0..CLKS_PER_BIT-1 (8 bits for a maximum of 256). The counter is inactive in IDLE.

## Timing
- Acceptance edge at cycle T. SHIFT occupies cycles T+1 .. T+8·CLKS_PER_BIT.
- Bit k (k=0..7) is presented during cycles T+1+k·CLKS_PER_BIT .. T+(k+1)·CLKS_PER_BIT.
- done and in_ready are high in cycle T+8·CLKS_PER_BIT+1. A new word can be accepted at that edge.
- Minimum word period is 8·CLKS_PER_BIT+1 cycles. bit_valid is low for exactly one cycle between back-to-back words.
- All outputs are registered; there is no combinational path from inputs to outputs.
- After reset release, in_ready first rises one cycle later.

## Test plan
- CLKS_PER_BIT=1, LSB-first, load 0xA5 at T:
  - sel = 0,1,…,7 in cycles T+1..T+8.
  - Mux y = 1,0,1,0,0,1,0,1.
  - bit_first at T+1, bit_last at T+8, done and in_ready at T+9.
- CLKS_PER_BIT=3, load 0x3C: each sel value is held exactly 3 cycles, bit_valid is high for 24 cycles, and done is at T+25.
- MSB_FIRST=1, load 0x81:
  - sel = 7→0.
  - y = 1,0,0,0,0,0,0,1.
  - bit_first with sel=7, bit_last with sel=0.
- in_valid held high continuously with in_data changing every cycle:
  - Words are accepted only at T and T+9 (CLKS_PER_BIT=1).
  - d equals the in_data sampled at each acceptance.
  - There is a one-cycle bit_valid gap between the two words.
- rst asserted for one cycle while sel=4:
  - Next cycle all outputs are at reset values and no done pulse occurs.
  - in_ready rises one cycle after rst deasserts.
  - A following word serializes normally.
- in_data toggled during SHIFT with in_valid=1: d and the serial bits are unaffected, and in_ready stays 0 until done.
